stream_downsizer: RTL
=====================

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter W_IN, default 32, input word width.
REQ-002 SHALL have parameter W_OUT, default 8, output chunk width; W_IN = RATIO*W_OUT, RATIO a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_rdata  input  W_IN  upstream buffer head word, valid when in_empty low.
REQ-006 SHALL have port in_empty  input  1  upstream buffer empty flag (registered upstream).
REQ-007 SHALL have port in_ren  output  1  pop strobe to upstream buffer.
REQ-008 SHALL have port flush  input  1  discard held word and any partial progress.
REQ-009 SHALL have port out_data  output  W_OUT  current chunk.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts chunk this cycle.
REQ-012 SHALL have port out_last  output  1  current chunk is final chunk of its word.

Function
REQ-013 SHALL hold state: holding flag, word register (W_IN), chunk index (log2(RATIO) bits).
REQ-014 SHALL drive out_valid = holding; out_last = holding AND index == RATIO-1.
REQ-015 SHALL drive out_data as chunk selected by index from word register; all-zero when not holding.
REQ-016 SHALL drive in_ren = !in_empty AND !flush AND (!holding OR (out_ready AND out_last)); never asserted while in_empty high.
REQ-017 On in_ren: word register <= in_rdata, index <= 0, holding <= 1; first chunk valid the following cycle (latency 1).
REQ-018 On out_valid AND out_ready AND !out_last: index <= index+1.
REQ-019 On out_valid AND out_ready AND out_last without in_ren: holding <= 0, index <= 0.
REQ-020 Last-chunk accept and pop in same cycle SHALL give sustained 1 chunk/cycle, no bubble between words.
REQ-021 While out_valid AND !out_ready, out_data, out_last and state SHALL remain unchanged.
REQ-022 flush SHALL take priority over all events: holding <= 0, index <= 0; an in-progress chunk accept that cycle is discarded.
REQ-023 Index SHALL never exceed RATIO-1; no wrap without a word boundary.

Reset
REQ-024 On rst_n low, immediately: holding 0, index 0, word register 0; hence out_valid 0, out_last 0, out_data 0, in_ren 0.
REQ-025 Reset mid-word SHALL drop the partial word; no chunk of it re-emitted after release.

Configuration
REQ-026 Macro STREAM_DOWNSIZER_MSB_FIRST_EN defined: index 0 selects bits [W_IN-1 -: W_OUT] (most-significant chunk first).
REQ-027 Macro undefined: index 0 selects bits [W_OUT-1:0] (least-significant chunk first); all other behaviour identical.

Structure
REQ-028 Shared package/header SHALL hold default widths and the chunk-index width function (log2 of RATIO).
REQ-029 Chunk select SHALL be one sub-module, stream_downsizer_mux (word, index -> chunk), order set by the macro.

Verification (W_IN=32, W_OUT=8)
REQ-030 Word 0xA1B2C3D4, out_ready=1, macro undefined -> D4,C3,B2,A1 on 4 consecutive cycles, out_last on 4th only, in_ren pulsed once.
REQ-031 Words 0x03020100, 0x07060504 queued, out_ready=1 -> 00..07 on 8 contiguous cycles; second in_ren coincides with first word's last chunk.
REQ-032 out_ready low 3 cycles at chunk 1 of 0xA1B2C3D4 -> out_data held 0xC3, out_valid high, in_ren low throughout.
REQ-033 flush at index 2, next word 0x11223344 available -> in_ren low in flush cycle, out_valid low next cycle, then 44,33,22,11.
REQ-034 STREAM_DOWNSIZER_MSB_FIRST_EN defined, 0xA1B2C3D4 -> A1,B2,C3,D4; rst_n low at index 1 -> out_valid 0, out_data 0 without clock edge.

Source files
------------

// File: rtl/stream_downsizer_pkg.sv
// Shared definitions for the stream downsizer: default widths, holding state
// encoding and the chunk-index width helper.
package stream_downsizer_pkg;

    localparam int unsigned W_IN_DEF  = 32;
    localparam int unsigned W_OUT_DEF = 8;

    // Holding flag expressed as a two-state machine
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Bits needed to index RATIO chunks (log2 of RATIO, minimum 1)
    function automatic int unsigned idx_width(input int unsigned ratio);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < ratio) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_downsizer_mux.sv
// Chunk select for the stream downsizer: picks one W_OUT slice of the held
// word by chunk index.
// Build option: STREAM_DOWNSIZER_MSB_FIRST_EN -> index 0 is the most
// significant chunk; otherwise index 0 is the least significant chunk.
module stream_downsizer_mux
    import stream_downsizer_pkg::*;
#(
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_OUT_DEF,
    localparam int unsigned RATIO = W_IN / W_OUT,
    localparam int unsigned IDX_W = idx_width(RATIO)
) (
    input  logic [W_IN-1:0]  i_word,
    input  logic [IDX_W-1:0] i_idx,
    output logic [W_OUT-1:0] o_chunk_c
);

    // One-hot compare over all chunk positions; order fixed at build time
    always_comb begin
        o_chunk_c = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i_idx == IDX_W'(i)) begin
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
                o_chunk_c = i_word[(RATIO - 1 - i) * W_OUT +: W_OUT];
`else
                o_chunk_c = i_word[i * W_OUT +: W_OUT];
`endif
            end
        end
    end

endmodule

// File: rtl/stream_downsizer.sv
// Stream downsizer: pops W_IN words from an upstream buffer and emits them
// as RATIO consecutive W_OUT chunks with valid/ready handshake.
// Build option: STREAM_DOWNSIZER_MSB_FIRST_EN selects most-significant chunk
// first (default: least-significant chunk first).
module stream_downsizer
    import stream_downsizer_pkg::*;
#(
    parameter int unsigned W_IN  = W_IN_DEF,
    parameter int unsigned W_OUT = W_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_IN-1:0]  in_rdata,
    input  logic             in_empty,
    output logic             in_ren,
    input  logic             flush,
    output logic [W_OUT-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned RATIO = W_IN / W_OUT;
    localparam int unsigned IDX_W = idx_width(RATIO);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    state_t           r_state;
    logic [W_IN-1:0]  r_word;
    logic [IDX_W-1:0] r_idx;

    logic             w_holding;
    logic             w_last;
    logic             w_accept;
    logic             w_pop;
    logic [W_OUT-1:0] w_chunk;

    assign w_holding = (r_state == ST_HOLD);
    assign w_last    = w_holding && (r_idx == IDX_LAST);
    assign w_accept  = w_holding && out_ready;

    // Pop when empty-handed, or when the last chunk leaves this cycle so the
    // next word follows without a bubble; reset and flush block the pop
    assign w_pop = rst_n && !in_empty && !flush &&
                   (!w_holding || (out_ready && w_last));

    stream_downsizer_mux #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_mux (
        .i_word    (r_word),
        .i_idx     (r_idx),
        .o_chunk_c (w_chunk)
    );

    assign in_ren    = w_pop;
    assign out_valid = w_holding;
    assign out_last  = w_last;
    assign out_data  = w_holding ? w_chunk : '0;

    // Holding state, word register and chunk index; flush overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else if (w_pop) begin
            r_state <= ST_HOLD;
            r_word  <= in_rdata;
            r_idx   <= '0;
        end else if (w_accept && !w_last) begin
            r_idx   <= r_idx + IDX_W'(1);
        end else if (w_accept && w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end
    end

endmodule
